// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller feeding decoder47: one guard cycle per slot,
// frame-boundary-synchronous reloads. Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  ready,
  output logic [7:0]            din,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic                  frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0][3:0]    disp_q, disp_d;
  logic [DIGITS-1:0][3:0]    shadow_q, shadow_d;
  logic                      pend_q, pend_d;
  logic                      frame_start_q, frame_start_d;

  logic slot_end;
  logic boundary;
  logic accept;

  assign slot_end = (pcnt_q == P_LAST);
  assign boundary = slot_end && (idx_q == I_LAST);
  assign accept   = load && !pend_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pcnt_d        = pcnt_q + PW'(1);
    idx_d         = idx_q;
    disp_d        = disp_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    frame_start_d = boundary;

    if (slot_end) begin
      pcnt_d = '0;
      idx_d  = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
    end

    // A pending frame is only swapped in on the last cycle of a frame; pend_q gates
    // acceptance, so a load landing on the boundary waits a full frame.
    if (boundary && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end

    if (accept) begin
      shadow_d = load_data;
      pend_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the digit storage is reset because the display must show zeros right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      disp_q        <= '0;
      shadow_q      <= '0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      frame_start_q <= frame_start_d;
    end
  end

  logic shown;

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] blank;
  logic              lead;

  // Walk down from the most significant digit while digits stay zero; digit 0 is always shown.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (disp_q[i] == 4'h0);
      blank[i] = lead;
    end
  end

  assign shown = !blank[idx_q];
`else
  assign shown = 1'b1;
`endif

  logic [DIGITS-1:0] onehot;

  assign onehot      = DIGITS'(1) << idx_q;
  assign digit_sel_n = ((pcnt_q == '0) || !shown) ? '1 : ~onehot;
  assign din         = {4'b0000, disp_q[idx_q]};
  assign ready       = !pend_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, PRESCALE=4): a cycle-count based frame model
// checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int P     = 4;
  localparam int FRAME = D * P;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_data = '0;
  logic          ready;
  logic [7:0]    din;
  logic [D-1:0]  digit_sel_n;
  logic          frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_data   (load_data),
    .ready       (ready),
    .din         (din),
    .digit_sel_n (digit_sel_n),
    .frame_start (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: cycle count since reset release, the frame on screen and a single pending slot.
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend;
  logic        m_boundary;

  assign m_boundary = (m_t % FRAME) == FRAME - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_disp   <= '0;
      m_shadow <= '0;
      m_pend   <= 1'b0;
    end else begin
      if (m_boundary && m_pend) begin
        m_disp <= m_shadow;
        m_pend <= 1'b0;
      end
      if (load && !m_pend) begin
        m_shadow <= load_data;
        m_pend   <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  function automatic logic [7:0] exp_din(input int t, input logic [15:0] disp);
    int i;
    i = (t / P) % D;
    return {4'h0, disp[4*i +: 4]};
  endfunction

  function automatic logic [D-1:0] exp_sel(input int t, input logic [15:0] disp);
    int i;
    int hi;
    i  = (t / P) % D;
    hi = 0;
    for (int k = 0; k < D; k++)
      if (disp[4*k +: 4] != 4'h0) hi = k;
    if ((t % P) == 0 || (LZB && i > hi)) return '1;
    return ~(D'(1) << i);
  endfunction

  always @(negedge clk) begin
    check("cmp_din",   din,         exp_din(m_t, m_disp));
    check("cmp_sel",   digit_sel_n, exp_sel(m_t, m_disp));
    check("cmp_ready", ready,       !m_pend);
    check("cmp_fs",    frame_start, (m_t % FRAME == 0) && (m_t != 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_load(input logic [15:0] data);
    load      = 1'b1;
    load_data = data;
    tick();
    load      = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel",   digit_sel_n, 4'hF);
    check("rst_din",   din,         8'h00);
    check("rst_ready", ready,       1'b1);
    check("rst_fs",    frame_start, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    go(1);  check("run_sel_c1",  digit_sel_n, 4'hE);
    go(4);  check("run_sel_c4",  digit_sel_n, 4'hF);
    go(5);  check("run_sel_c5",  digit_sel_n, 4'hD);
    go(16); check("run_fs_c16",  frame_start, 1'b1);
    go(17); check("run_fs_c17",  frame_start, 1'b0);

    go(20); do_load(16'h4321);
    check("ld_ready_low", ready, 1'b0);
    check("ld_din_old",   din,   8'h00);
    go(25); do_load(16'h9999);
    check("ign_ready",    ready, 1'b0);
    go(31); check("ld_ready_bnd", ready, 1'b0);
    go(32); check("ld_ready_hi",  ready, 1'b1);
            check("ld_din_d0",    din,   8'h01);
    go(36); check("ld_din_d1",    din,   8'h02);
    go(44); check("ld_din_d3",    din,   8'h04);
    go(60); check("ign_din_d3",   din,   8'h04);

    go(63); do_load(16'h5678);
    check("bnd_ready_low", ready, 1'b0);
    check("bnd_din_old",   din,   8'h01);
    go(80); check("bnd_din_new",   din,   8'h08);
            check("bnd_ready_hi",  ready, 1'b1);
    do_load(16'h1234);
    check("first_cycle_accept", ready, 1'b0);

    go(86);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel",   digit_sel_n, 4'hF);
    check("mid_rst_din",   din,         8'h00);
    check("mid_rst_ready", ready,       1'b1);
    check("mid_rst_fs",    frame_start, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    go(16); check("disc_din_c16", din, 8'h00);
    go(32); check("disc_din_c32", din, 8'h00);

    go(36); do_load(16'h0050);
    go(49); check("lz_din_d0", din, 8'h00);
            check("lz_sel_d0", digit_sel_n, 4'hE);
    go(53); check("lz_din_d1", din, 8'h05);
            check("lz_sel_d1", digit_sel_n, 4'hD);
    go(57); check("lz_din_d2", din, 8'h00);
            check("lz_sel_d2", digit_sel_n, LZB ? 4'hF : 4'hB);
    go(61); check("lz_sel_d3", digit_sel_n, LZB ? 4'hF : 4'h7);

    go(64); do_load(16'h0000);
    go(81); check("z_sel_d0", digit_sel_n, 4'hE);
    go(85); check("z_sel_d1", digit_sel_n, LZB ? 4'hF : 4'hD);
    go(93); check("z_sel_d3", digit_sel_n, LZB ? 4'hF : 4'h7);
            check("z_din_d3", din, 8'h00);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
